// File: rtl/pad_io_hub.sv
// pad_io_hub: memory-mapped hub for sensor pads, pad lights, hand controller and VGA outputs.
// Latency: pad_raw -> pad_stable edge k+1+DEB_CYCLES; hit/light/score/mistake edge k+2+DEB_CYCLES; rdata one edge after rden.
// Backpressure: none; every processor access completes in a single cycle, strobes are never stalled.
//
// Ports:
//   clock, resetn          - system clock (rising edge), async active-low reset
//   pad_raw, ctrl_raw      - asynchronous pad / controller levels
//   addr, wren, rden,      - processor register port (single-cycle strobes)
//   wdata, rdata
//   light, screen, score,  - pad light drive and VGA-side state
//   mistake
//   hit_irq                - high while any captured hit is pending

module pad_io_hub #(
   parameter int NUM_PADS   = 3,
   parameter int CTRL_W     = 3,
   parameter int DEB_CYCLES = 16,
   parameter bit AUTO_SCORE = 1'b1
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [NUM_PADS-1:0] pad_raw,
   input  logic [CTRL_W-1:0]   ctrl_raw,
   input  logic [2:0]          addr,
   input  logic                wren,
   input  logic                rden,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic [NUM_PADS-1:0] light,
   output logic [3:0]          screen,
   output logic [31:0]         score,
   output logic                mistake,
   output logic                hit_irq
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_LOW,
      ST_CONF_HIGH,
      ST_HIGH,
      ST_CONF_LOW
   } deb_state_e;

   // ------------------------------------------------------------------
   // Two-flop synchronisers
   // ------------------------------------------------------------------
   logic [NUM_PADS-1:0] pad_s1_q, pad_s2_q;
   logic [CTRL_W-1:0]   ctrl_s1_q, ctrl_sync_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pad_s1_q    <= '0;
         pad_s2_q    <= '0;
         ctrl_s1_q   <= '0;
         ctrl_sync_q <= '0;
      end else begin
         pad_s1_q    <= pad_raw;
         pad_s2_q    <= pad_s1_q;
         ctrl_s1_q   <= ctrl_raw;
         ctrl_sync_q <= ctrl_s1_q;
      end
   end

   // ------------------------------------------------------------------
   // Per-pad debounce FSMs
   // ------------------------------------------------------------------
   logic [NUM_PADS-1:0] pad_stable;

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_deb
      deb_state_e       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // The count that would reach DEB_CYCLES moves straight to the
      // settled state, so the settled state is entered on the edge where
      // the DEB_CYCLES-th consecutive stable sample is taken.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            ST_LOW: begin
               if (pad_s2_q[g]) begin
                  state_d = ST_CONF_HIGH;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_CONF_HIGH: begin
               if (!pad_s2_q[g]) begin
                  state_d = ST_LOW;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                  state_d = ST_HIGH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_HIGH: begin
               if (!pad_s2_q[g]) begin
                  state_d = ST_CONF_LOW;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_CONF_LOW: begin
               if (pad_s2_q[g]) begin
                  state_d = ST_HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                  state_d = ST_LOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end
         endcase
      end

      assign pad_stable[g] = (state_q == ST_HIGH) || (state_q == ST_CONF_LOW);
   end

   // ------------------------------------------------------------------
   // Hit detection: rising edge of pad_stable
   // ------------------------------------------------------------------
   logic [NUM_PADS-1:0] stable_prev_q;
   logic [NUM_PADS-1:0] hit;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) stable_prev_q <= '0;
      else         stable_prev_q <= pad_stable;
   end

   assign hit = pad_stable & ~stable_prev_q;

   // ------------------------------------------------------------------
   // Register file and hardware scoring
   // ------------------------------------------------------------------
   logic [NUM_PADS-1:0] light_q, light_d;
   logic [3:0]          screen_q, screen_d;
   logic [31:0]         score_q, score_d;
   logic                mistake_q, mistake_d;
   logic [NUM_PADS-1:0] hit_pend_q, hit_pend_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                wr_light, wr_screen, wr_score, wr_mistake, rd_pend;
   logic [NUM_PADS-1:0] lit_hits, miss_hits;
   logic [4:0]          lit_cnt;
   logic [32:0]         score_sum;
   logic [31:0]         score_sat;
   logic [31:0]         rd_val;

   assign wr_light   = wren && (addr == 3'd1);
   assign wr_screen  = wren && (addr == 3'd3);
   assign wr_score   = wren && (addr == 3'd4);
   assign wr_mistake = wren && (addr == 3'd5);
   assign rd_pend    = rden && (addr == 3'd6);

   assign lit_hits  = hit & light_q;
   assign miss_hits = hit & ~light_q;

   always_comb begin
      lit_cnt = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         lit_cnt = lit_cnt + {4'd0, lit_hits[i]};
      end
   end

   assign score_sum = {1'b0, score_q} + 33'(lit_cnt);
   assign score_sat = score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];

   always_comb begin
      rd_val = '0;
      case (addr)
         3'd0: rd_val = 32'(pad_stable);
         3'd1: rd_val = 32'(light_q);
         3'd2: rd_val = 32'(ctrl_sync_q);
         3'd3: rd_val = {28'd0, screen_q};
         3'd4: rd_val = score_q;
         3'd5: rd_val = {31'd0, mistake_q};
         3'd6: rd_val = 32'(hit_pend_q);
         3'd7: rd_val = {16'd0, 8'(CTRL_W), 8'(NUM_PADS)};
         default: rd_val = '0;
      endcase
   end

   always_comb begin
      light_d   = light_q;
      screen_d  = screen_q;
      score_d   = score_q;
      mistake_d = mistake_q;

      if (AUTO_SCORE) begin
         light_d = light_q & ~lit_hits;
         score_d = score_sat;
         if (|miss_hits) mistake_d = 1'b1;
      end

      // Processor writes override the hardware update of the same register.
      if (wr_light)   light_d   = wdata[NUM_PADS-1:0];
      if (wr_screen)  screen_d  = wdata[3:0];
      if (wr_score)   score_d   = wdata;
      if (wr_mistake) mistake_d = wdata[0];

      // A new hit survives a same-cycle read-clear.
      hit_pend_d = (rd_pend ? '0 : hit_pend_q) | hit;

      rdata_d = rden ? rd_val : rdata_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         light_q    <= '0;
         screen_q   <= '0;
         score_q    <= '0;
         mistake_q  <= 1'b0;
         hit_pend_q <= '0;
         rdata_q    <= '0;
      end else begin
         light_q    <= light_d;
         screen_q   <= screen_d;
         score_q    <= score_d;
         mistake_q  <= mistake_d;
         hit_pend_q <= hit_pend_d;
         rdata_q    <= rdata_d;
      end
   end

   assign rdata   = rdata_q;
   assign light   = light_q;
   assign screen  = screen_q;
   assign score   = score_q;
   assign mistake = mistake_q;
   assign hit_irq = |hit_pend_q;

endmodule

// File: tb/tb_pad_io_hub.sv
// tb_pad_io_hub: directed checks of pad_io_hub with DEB_CYCLES=4, three pads, hardware scoring on.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 unit after the following edge.
// Backpressure: not applicable.

module tb_pad_io_hub;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [2:0]  pad_raw = '0;
   logic [2:0]  ctrl_raw = '0;
   logic [2:0]  addr = '0;
   logic        wren = 1'b0;
   logic        rden = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [2:0]  light;
   logic [3:0]  screen;
   logic [31:0] score;
   logic        mistake;
   logic        hit_irq;

   int n_vec = 0;
   int n_err = 0;

   pad_io_hub #(
      .NUM_PADS  (3),
      .CTRL_W    (3),
      .DEB_CYCLES(4),
      .AUTO_SCORE(1'b1)
   ) dut (
      .clock   (clock),
      .resetn  (resetn),
      .pad_raw (pad_raw),
      .ctrl_raw(ctrl_raw),
      .addr    (addr),
      .wren    (wren),
      .rden    (rden),
      .wdata   (wdata),
      .rdata   (rdata),
      .light   (light),
      .screen  (screen),
      .score   (score),
      .mistake (mistake),
      .hit_irq (hit_irq)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wren  = 1'b1;
      step();
      wren  = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a);
      addr = a;
      rden = 1'b1;
      step();
      rden = 1'b0;
   endtask

   // Press for 7 edges (hit effects visible after the 7th), then release
   // for 7 edges so the pad settles back to LOW.
   task automatic hit_pad(input logic [2:0] mask);
      pad_raw = mask;
      repeat (7) step();
      pad_raw = '0;
      repeat (7) step();
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_light",   32'(light),   32'd0);
      chk("rst_screen",  32'(screen),  32'd0);
      chk("rst_score",   score,        32'd0);
      chk("rst_mistake", 32'(mistake), 32'd0);
      chk("rst_rdata",   rdata,        32'd0);
      chk("rst_irq",     32'(hit_irq), 32'd0);
      resetn = 1'b1;
      step();

      // Debounce timing: pad 0 sampled high at edge 0, stable after edge 5,
      // hit registered at edge 6.
      pad_raw = 3'b001;
      step();                 // edge 0
      repeat (4) step();      // edges 1..4
      addr = 3'd0;
      rden = 1'b1;
      step();                 // edge 5: samples pad_stable before it rises
      chk("deb_rd_e5",  rdata,        32'd0);
      chk("deb_irq_e5", 32'(hit_irq), 32'd0);
      step();                 // edge 6
      rden = 1'b0;
      chk("deb_rd_e6",  rdata,        32'd1);
      chk("deb_irq_e6", 32'(hit_irq), 32'd1);
      chk("deb_miss",   32'(mistake), 32'd1);
      chk("deb_score",  score,        32'd0);
      rd(3'd6);
      chk("pend_rd",    rdata,        32'd1);
      chk("pend_clr",   32'(hit_irq), 32'd0);
      pad_raw = '0;
      repeat (7) step();
      rd(3'd0);
      chk("stable_low", rdata,        32'd0);

      // 3-cycle glitch on pad 1 is rejected
      pad_raw = 3'b010;
      repeat (3) step();
      pad_raw = '0;
      repeat (10) step();
      chk("glitch_irq", 32'(hit_irq), 32'd0);
      rd(3'd6);
      chk("glitch_pend", rdata,       32'd0);

      // Clear mistake
      wr(3'd5, 32'd0);
      chk("mist_clr",   32'(mistake), 32'd0);

      // Lit-pad scoring
      wr(3'd1, 32'd5);
      chk("light_wr",   32'(light),   32'd5);
      hit_pad(3'b100);
      chk("lit_light",  32'(light),   32'd1);
      chk("lit_score",  score,        32'd1);
      chk("lit_miss",   32'(mistake), 32'd0);
      rd(3'd6);
      chk("lit_pend",   rdata,        32'd4);

      // Wrong-pad mistake
      hit_pad(3'b010);
      chk("wrong_miss",  32'(mistake), 32'd1);
      chk("wrong_score", score,        32'd1);
      chk("wrong_light", 32'(light),   32'd1);
      rd(3'd6);
      chk("wrong_pend",  rdata,        32'd2);
      wr(3'd5, 32'd0);
      chk("wrong_clr",   32'(mistake), 32'd0);

      // Simultaneous lit hits add 2
      wr(3'd1, 32'd5);
      hit_pad(3'b101);
      chk("dual_score", score,       32'd3);
      chk("dual_light", 32'(light),  32'd0);
      rd(3'd6);
      chk("dual_pend",  rdata,       32'd5);

      // Score write coincides with a lit hit (edge 6)
      wr(3'd1, 32'd1);
      pad_raw = 3'b001;
      repeat (6) step();      // edges 0..5
      wr(3'd4, 32'd100);      // edge 6
      chk("coll_score", score,        32'd100);
      chk("coll_light", 32'(light),   32'd0);
      chk("coll_irq",   32'(hit_irq), 32'd1);
      pad_raw = '0;
      repeat (7) step();
      rd(3'd6);
      chk("coll_pend",  rdata,        32'd1);

      // Read-clear race: pending pad 0, read at the edge pad 1 hits
      hit_pad(3'b001);
      pad_raw = 3'b010;
      repeat (6) step();      // edges 0..5
      rd(3'd6);               // edge 6
      chk("race_rdata", rdata,        32'd1);
      chk("race_irq",   32'(hit_irq), 32'd1);
      pad_raw = '0;
      repeat (7) step();
      rd(3'd6);
      chk("race_pend",  rdata,        32'd2);
      chk("race_score", score,        32'd100);
      wr(3'd5, 32'd0);

      // Saturation
      wr(3'd4, 32'hFFFF_FFFF);
      wr(3'd1, 32'd1);
      hit_pad(3'b001);
      chk("sat_score",  score,        32'hFFFF_FFFF);
      chk("sat_light",  32'(light),   32'd0);
      rd(3'd6);

      // Misc registers
      ctrl_raw = 3'b101;
      repeat (3) step();
      rd(3'd2);
      chk("ctrl_rd",    rdata,        32'd5);
      wr(3'd3, 32'hFFFF_FFFA);
      chk("screen_wr",  32'(screen),  32'hA);
      rd(3'd3);
      chk("screen_rd",  rdata,        32'hA);
      wr(3'd7, 32'h1234_5678);
      wr(3'd0, 32'hFFFF_FFFF);
      rd(3'd7);
      chk("id_rd",      rdata,        32'h0000_0303);
      rd(3'd0);
      chk("ro_pad",     rdata,        32'd0);
      wr(3'd1, 32'd7);

      // Reset mid-debounce
      pad_raw = 3'b001;
      repeat (3) step();
      resetn  = 1'b0;
      pad_raw = '0;
      #1;
      chk("arst_light",  32'(light),   32'd0);
      chk("arst_screen", 32'(screen),  32'd0);
      chk("arst_score",  score,        32'd0);
      chk("arst_rdata",  rdata,        32'd0);
      chk("arst_miss",   32'(mistake), 32'd0);
      step();
      resetn = 1'b1;
      repeat (10) step();
      chk("post_irq",    32'(hit_irq), 32'd0);
      chk("post_miss",   32'(mistake), 32'd0);
      rd(3'd6);
      chk("post_pend",   rdata,        32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pad_io_hub.md
# pad_io_hub

Memory-mapped I/O hub between the game processor and the physical game hardware: N sensor pads, pad lights, the hand controller, and the screen/score/mistake outputs consumed by the VGA controller. It supersedes the fixed 3-pad, address-0..5 wiring with a channel-parametrised block. The block adds input synchronisation, per-pad debouncing, sticky hit capture with read-clear, and an optional hardware scoring mode that updates score and mistake without processor involvement.

## Interface
Parameters:
- NUM_PADS, 3, number of sensor pads and pad lights (1..16).
- CTRL_W, 3, controller input width (1..32).
- DEB_CYCLES, 16, consecutive stable cycles needed to accept a pad change (2..255).
- AUTO_SCORE, 1, 1 = hardware scoring enabled, 0 = processor-only.

Ports:
- clock, in, 1, single system clock; all logic on rising edge.
- resetn, in, 1, asynchronous active-low reset.
- pad_raw, in, NUM_PADS, asynchronous pad sensor levels, 1 = pressed.
- ctrl_raw, in, CTRL_W, asynchronous controller levels.
- addr, in, 3, processor register address.
- wren, in, 1, write strobe, one cycle per write.
- rden, in, 1, read strobe, one cycle per read.
- wdata, in, 32, write data.
- rdata, out, 32, registered read data.
- light, out, NUM_PADS, pad light drive, 1 = lit.
- screen, out, 4, screen select to VGA: bit0 splash, bit1 dummy, bit2 leaderboard, bit3 screen-change.
- score, out, 32, current score to VGA.
- mistake, out, 1, sticky wrong-pad flag to VGA.
- hit_irq, out, 1, high while any hit_pend bit is set.

## Operation
- Two-flop synchroniser on every pad_raw and ctrl_raw bit; ctrl_sync is the second flop.
- Per-pad debounce FSM. States: LOW, CONFIRM_HIGH, HIGH, CONFIRM_LOW. In LOW with sync=1 -> CONFIRM_HIGH, counter=1. In CONFIRM_HIGH: sync=0 -> LOW; counter reaching DEB_CYCLES -> HIGH. HIGH/CONFIRM_LOW mirror this. pad_stable[i] = 1 in HIGH and CONFIRM_LOW. Counter width is ceil(log2(DEB_CYCLES+1)).
- Hit: a transition of pad_stable[i] 0->1 sets hit_pend[i], registered one cycle after pad_stable rises.
- Register map:
  - 0 R: pad_stable, zero-extended.
  - 1 R/W: light[NUM_PADS-1:0].
  - 2 R: ctrl_sync.
  - 3 R/W: screen[3:0].
  - 4 R/W: score.
  - 5 R/W: mistake (bit0).
  - 6 R: hit_pend, cleared by the read.
  - 7 R: {16'd0, 8'd CTRL_W, 8'd NUM_PADS}.
- Writes to read-only addresses are ignored. Unused upper read bits are 0.
- AUTO_SCORE=1, on each hit of pad i:
  - If light[i]=1: light[i] is cleared and score increments.
  - If light[i]=0: mistake is set.
  - Simultaneous hits on k lit pads add k to score.
  - Score saturates at 32'hFFFFFFFF.
- AUTO_SCORE=0: hits only set hit_pend.
- Collisions in the same cycle:
  - A processor write to score, light, or mistake takes precedence over the hardware update of that register.
  - A new hit on bit i during an address-6 read leaves bit i set (set beats clear). rdata returns the pre-clear value.
- mistake stays set until the processor writes 0 or reset asserts.

## Timing
- Reset (async assert, sync-free deassert accepted): light=0, screen=0, score=0, mistake=0, rdata=0, hit_pend=0, hit_irq=0, all FSMs in LOW, synchronisers 0.
- Reset mid-debounce discards the pending count.
- rdata is valid on the edge after rden and holds its value until the next read.
- Write effect is visible on outputs the edge after wren.
- Latency from pad_raw change (sampled at edge k) to pad_stable: edge k+1+DEB_CYCLES. This is 2 synchroniser edges, with the first count on the second.
- hit_pend, light, score, and mistake update at edge k+2+DEB_CYCLES.
- hit_irq is combinational from hit_pend.
- A glitch shorter than DEB_CYCLES synchronised cycles produces no pad_stable change and no hit.

## Test plan
- Debounce and hit capture: DEB_CYCLES=4. Hold pad_raw[0]=1 from edge 0 -> pad_stable[0]=1 at edge 5, hit_pend=3'b001 and hit_irq=1 at edge 6. A 3-cycle pulse on pad 1 -> no change.
- Lit-pad scoring: AUTO_SCORE=1, write addr1=3'b101, then hit pad 2 -> light=3'b001, score=1, mistake=0.
- Wrong-pad mistake: light=3'b001, hit pad 1 -> mistake=1, score unchanged. Then write addr5=0 -> mistake=0.
- Simultaneous events: hit on lit pads 0 and 2 in one cycle -> score +2. A score write of 100 in the same cycle as a hit -> score=100.
- Read-clear race: hit_pend=3'b001, read addr6 in the same cycle pad 1 hits -> rdata=1, hit_pend=3'b010 afterwards.
- Saturation and reset: write score=32'hFFFFFFFF, lit hit -> score stays FFFFFFFF. Assert resetn=0 mid-debounce -> all outputs 0 immediately, no hit after release.
